// File: rtl/bam_seq_mul.sv
// Sequential broken-array multiplier: one masked partial-product row per cycle
// through a single row adder, skipping rows removed by the horizontal cut.
module bam_seq_mul #(
    parameter int N = 8,
    parameter int H = 5,
    parameter int V = 12
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    input  logic           exact,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-1:0] out
);

    // Handshakes: a transfer happens on a rising edge where valid && ready;
    // in_ready is high only in IDLE, out_valid only in DONE, and out (the
    // accumulator) is held stable while out_valid waits for out_ready.

    localparam int RW = $clog2(N + 1);
    // Start row for approximate mode; a cut at or beyond N leaves no rows.
    localparam logic [RW-1:0] H_ROW    = (H >= N) ? RW'(N) : RW'(H);
    localparam logic [RW-1:0] LAST_ROW = RW'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [N-1:0]     a_q, a_d;
    logic [N-1:0]     b_q, b_d;
    logic             exact_q, exact_d;
    logic [2*N-1:0]   acc_q, acc_d;
    logic [RW-1:0]    row_q, row_d;

    logic [N-1:0]     mask;
    logic             b_bit;
    logic [2*N-1:0]   addend;

    // Row mask keeps column i when i+row reaches the vertical cut.
    always_comb begin
        mask  = '0;
        b_bit = 1'b0;
        for (int i = 0; i < N; i++) begin
            mask[i] = exact_q || ((i + int'(row_q)) >= V);
            if (row_q == RW'(i)) begin
                b_bit = b_q[i];
            end
        end
        addend = {{N{1'b0}}, a_q & mask} << row_q;
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        exact_d = exact_q;
        acc_d   = acc_q;
        row_d   = row_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    exact_d = exact;
                    acc_d   = '0;
                    if (exact) begin
                        row_d   = '0;
                        state_d = RUN;
                    end else begin
                        row_d   = H_ROW;
                        state_d = (H < N) ? RUN : DONE;
                    end
                end
            end
            RUN: begin
                if (b_bit) begin
                    acc_d = acc_q + addend;
                end
                row_d = row_q + RW'(1);
                if (row_q == LAST_ROW) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            exact_q <= 1'b0;
            acc_q   <= '0;
            row_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            exact_q <= exact_d;
            acc_q   <= acc_d;
            row_q   <= row_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign out       = acc_q;

endmodule

// File: tb/tb_bam_seq_mul.sv
// Bench for bam_seq_mul: directed cases plus a random sweep against a
// partial-product-level BAM reference model.
module tb_bam_seq_mul;

    localparam int N = 8;
    localparam int H = 5;
    localparam int V = 12;

    logic           clk;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic [N-1:0]   a;
    logic [N-1:0]   b;
    logic           exact;
    logic           out_valid;
    logic           out_ready;
    logic [2*N-1:0] out;

    int checks;
    int failures;

    bam_seq_mul #(.N(N), .H(H), .V(V)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .exact     (exact),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference: sum every kept partial product a[i]&b[j] at weight 2^(i+j)
    function automatic logic [2*N-1:0] bam_ref(input logic [N-1:0] xa,
                                               input logic [N-1:0] xb,
                                               input logic xe);
        int s;
        s = 0;
        for (int j = 0; j < N; j++)
            for (int i = 0; i < N; i++)
                if (xa[i] && xb[j] && (xe || (j >= H && i + j >= V)))
                    s += (1 << (i + j));
        return (2*N)'(s);
    endfunction

    function automatic int exp_lat(input logic xe);
        int r;
        r = xe ? N : ((H >= N) ? 0 : N - H);
        return r + 1;
    endfunction

    // driver + checker for one transaction; noise pulses in_valid while busy
    task automatic do_op(input logic [N-1:0] xa, input logic [N-1:0] xb,
                         input logic xe, input logic [2*N-1:0] exp_out,
                         input int stall, input bit noise, input string tag);
        int lat;
        @(negedge clk);
        a = xa; b = xb; exact = xe; in_valid = 1'b1; out_ready = 1'b0;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL %s accept_ready: in_ready=%b required 1", tag, in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (out_valid !== 1'b1 && lat < 40) begin
            checks++;
            if (in_ready !== 1'b0) begin
                failures++;
                $display("FAIL %s busy_ready: in_ready=%b required 0 at cycle %0d", tag, in_ready, lat);
            end
            if (noise && $urandom_range(0, 1) == 1) begin
                a = N'($urandom); b = N'($urandom); exact = 1'($urandom); in_valid = 1'b1;
            end
            @(negedge clk);
            in_valid = 1'b0;
            lat++;
        end
        checks++;
        if (out_valid !== 1'b1 || lat != exp_lat(xe)) begin
            failures++;
            $display("FAIL %s latency: out_valid=%b after %0d cycles required %0d", tag, out_valid, lat, exp_lat(xe));
        end
        checks++;
        if (out !== exp_out) begin
            failures++;
            $display("FAIL %s product: a=%0d b=%0d exact=%b out=%0d required %0d", tag, xa, xb, xe, out, exp_out);
        end
        for (int k = 0; k < stall; k++) begin
            if (noise) begin
                a = N'($urandom); b = N'($urandom); exact = 1'($urandom); in_valid = 1'b1;
            end
            @(negedge clk);
            in_valid = 1'b0;
            checks++;
            if (out_valid !== 1'b1 || out !== exp_out || in_ready !== 1'b0) begin
                failures++;
                $display("FAIL %s stall: out_valid=%b out=%0d in_ready=%b required 1/%0d/0", tag, out_valid, out, in_ready, exp_out);
            end
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL %s handshake: out_valid=%b in_ready=%b required 0/1", tag, out_valid, in_ready);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; exact = 1'b0;
        #12;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out !== '0) begin
            failures++;
            $display("FAIL reset_values: in_ready=%b out_valid=%b out=%0d required 1/0/0", in_ready, out_valid, out);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_exact;
        do_op(8'd255, 8'd255, 1'b1, 16'd65025, 0, 1'b0, "exact_max");
    endtask

    task automatic test_approx;
        do_op(8'd255, 8'd255, 1'b0, 16'hB000, 0, 1'b0, "approx_max");
        do_op(8'h80, 8'h80, 1'b0, 16'd16384, 1, 1'b0, "approx_msb");
        do_op(8'h7F, 8'h1F, 1'b0, 16'd0, 0, 1'b0, "approx_cut_rows");
    endtask

    task automatic test_backpressure;
        do_op(8'hA5, 8'hC3, 1'b0, bam_ref(8'hA5, 8'hC3, 1'b0), 5, 1'b1, "bp_approx");
        do_op(8'hA5, 8'hC3, 1'b1, 16'hA5 * 16'hC3, 5, 1'b1, "bp_exact");
    endtask

    task automatic test_reset_mid;
        @(negedge clk);
        a = 8'd255; b = 8'd255; exact = 1'b1; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_mid: out_valid=%b in_ready=%b required 0/1", out_valid, in_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        do_op(8'd3, 8'd5, 1'b1, 16'd15, 0, 1'b0, "after_reset");
    endtask

    // in_valid and out_ready held high: accepts must be R+2 cycles apart
    task automatic test_back_to_back;
        int acc_cyc[$];
        @(negedge clk);
        a = 8'd255; b = 8'd255; exact = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        for (int c = 0; c < 22; c++) begin
            if (in_ready === 1'b1) acc_cyc.push_back(c);
            if (out_valid === 1'b1) begin
                checks++;
                if (out !== 16'hB000) begin
                    failures++;
                    $display("FAIL b2b_product: out=%0d required %0d", out, 16'hB000);
                end
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        checks++;
        if (acc_cyc.size() < 4) begin
            failures++;
            $display("FAIL b2b_count: accepts=%0d required at least 4", acc_cyc.size());
        end
        for (int k = 1; k < acc_cyc.size(); k++) begin
            checks++;
            if (acc_cyc[k] - acc_cyc[k-1] != exp_lat(1'b0) + 1) begin
                failures++;
                $display("FAIL b2b_period: gap=%0d required %0d", acc_cyc[k] - acc_cyc[k-1], exp_lat(1'b0) + 1);
            end
        end
        repeat (12) @(negedge clk);
        if (out_valid === 1'b1) begin
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
        end
    endtask

    task automatic test_random;
        logic [N-1:0] ra, rb;
        logic         re;
        for (int t = 0; t < 2000; t++) begin
            ra = N'($urandom);
            rb = N'($urandom);
            re = 1'($urandom);
            do_op(ra, rb, re, bam_ref(ra, rb, re), $urandom_range(0, 3), 1'($urandom), "random");
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset;
        test_exact;
        test_approx;
        test_backpressure;
        test_reset_mid;
        test_back_to_back;
        test_random;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
